tcl_pop_arbiter: RTL and testbench

TCL_POP_ARBITER -- requirements
Module: tcl_pop_arbiter

---
 rtl/tcl_pkg.sv | 25 ++
 rtl/rr_select.sv | 50 +++++
 rtl/tcl_pop_arbiter.sv | 155 +++++++++++++++
 tb/tb_tcl_pop_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcl_pkg.sv
// -----------------------------------------------------------------------------
// tcl_pkg
// Shared definitions for the TCL pop arbiter:
//   NPORTS / IDX_W        default port count and grant-index width
//   TH_W                  threshold width
//   UMBRAL_*_RST          threshold values loaded on reset
//   state_t               arbiter FSM encoding (visible on the 'state' port)
// -----------------------------------------------------------------------------
package tcl_pkg;

   localparam int NPORTS = 4;
   localparam int IDX_W  = 2;
   localparam int TH_W   = 3;

   localparam logic [TH_W-1:0] UMBRAL_BAJO_RST = 3'd1;
   localparam logic [TH_W-1:0] UMBRAL_ALTO_RST = 3'd6;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker (masked priority encoder).
// Chooses the lowest-index requester strictly above i_last; if none exists,
// wraps and chooses the lowest-index requester overall.
//   i_req   [N-1:0]  request vector (bit i = port i)
//   i_last  [W-1:0]  index granted most recently
//   o_found          at least one request present
//   o_idx   [W-1:0]  selected index (0 when o_found = 0)
// -----------------------------------------------------------------------------
module rr_select
   import tcl_pkg::*;
#(
   parameter int N = NPORTS,
   parameter int W = IDX_W
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic         o_found,
   output logic [W-1:0] o_idx
);

   logic         w_lo_found;
   logic [W-1:0] w_lo_idx;
   logic         w_hi_found;
   logic [W-1:0] w_hi_idx;

   // Scan from the top down so the last hit written is the lowest index.
   // The "hi" half only accepts requesters above i_last (the masked search).
   always_comb begin
      w_lo_found = 1'b0;
      w_lo_idx   = '0;
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_lo_found = 1'b1;
            w_lo_idx   = W'(i);
            if (i > int'(i_last)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = W'(i);
            end
         end
      end
   end

   assign o_found = w_lo_found;
   assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/tcl_pop_arbiter.sv
// -----------------------------------------------------------------------------
// tcl_pop_arbiter
// Schedules single-word pops from NPORTS output FIFOs towards one sink.
//
// Ports
//   clk, reset (async, active low)
//   init                      load thresholds and (re)start scheduling
//   Umbral_bajo_in/alto_in    candidate thresholds (accepted only if bajo < alto)
//   fifoEmpty[NPORTS]         per-port empty flag
//   fifoAlmostFull[NPORTS]    per-port almost-full flag (urgent service)
//   sinkReady                 sink can take one word
//   popOutP0..P3              one-cycle pop strobes (registered)
//   grantIdx / grantValid     index of the port popped this cycle / strobe valid
//   Umbral_bajo/alto          latched thresholds driven to the FIFOs
//   cfgError                  sticky: last INIT saw an invalid threshold pair
//   state                     FSM state (RESET=0, INIT=1, IDLE=2, ACTIVE=3)
//
// Handshake: a grant is decided at edge k from fifoEmpty/fifoAlmostFull/
// sinkReady sampled at that edge; the pop strobe, grantIdx and grantValid are
// then high for exactly cycle k+1. sinkReady=1 at edge k is the sink's promise
// to accept that word in cycle k+1; no pop is issued without it.
// -----------------------------------------------------------------------------
module tcl_pop_arbiter #(
   parameter int NPORTS = tcl_pkg::NPORTS,
   parameter int IDX_W  = tcl_pkg::IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [2:0]        Umbral_bajo_in,
   input  logic [2:0]        Umbral_alto_in,
   input  logic [NPORTS-1:0] fifoEmpty,
   input  logic [NPORTS-1:0] fifoAlmostFull,
   input  logic              sinkReady,
   output logic              popOutP0,
   output logic              popOutP1,
   output logic              popOutP2,
   output logic              popOutP3,
   output logic [IDX_W-1:0]  grantIdx,
   output logic              grantValid,
   output logic [2:0]        Umbral_bajo,
   output logic [2:0]        Umbral_alto,
   output logic              cfgError,
   output logic [1:0]        state
);

   tcl_pkg::state_t    r_state;
   logic [NPORTS-1:0]  r_pop;
   logic [IDX_W-1:0]   r_grant_idx;
   logic               r_grant_valid;
   logic [IDX_W-1:0]   r_last_grant;
   logic [2:0]         r_bajo;
   logic [2:0]         r_alto;
   logic               r_cfg_err;

   logic [NPORTS-1:0]  w_elig;
   logic [NPORTS-1:0]  w_af;
   logic               w_af_found;
   logic [IDX_W-1:0]   w_af_idx;
   logic               w_rr_found;
   logic [IDX_W-1:0]   w_rr_idx;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_serving;
   logic               w_do_grant;

   // A FIFO's empty flag lags its pop by one cycle, so the port popped in the
   // current cycle (r_pop) is skipped to avoid popping a FIFO that just drained.
   assign w_elig = ~fifoEmpty & ~r_pop;
   assign w_af   = w_elig & fifoAlmostFull;

   // Lowest-index eligible almost-full port wins outright.
   always_comb begin
      w_af_found = 1'b0;
      w_af_idx   = '0;
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (w_af[i]) begin
            w_af_found = 1'b1;
            w_af_idx   = IDX_W'(i);
         end
      end
   end

   rr_select #(
      .N (NPORTS),
      .W (IDX_W)
   ) u_rr_select (
      .i_req   (w_elig),
      .i_last  (r_last_grant),
      .o_found (w_rr_found),
      .o_idx   (w_rr_idx)
   );

   assign w_sel_idx  = w_af_found ? w_af_idx : w_rr_idx;
   assign w_serving  = (r_state == tcl_pkg::ST_IDLE) || (r_state == tcl_pkg::ST_ACTIVE);
   assign w_do_grant = w_serving & ~init & sinkReady & w_rr_found;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= tcl_pkg::ST_RESET;
         r_pop         <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_last_grant  <= IDX_W'(NPORTS - 1);
         r_bajo        <= tcl_pkg::UMBRAL_BAJO_RST;
         r_alto        <= tcl_pkg::UMBRAL_ALTO_RST;
         r_cfg_err     <= 1'b0;
      end else begin
         // Pop strobes are single-cycle unless a new grant is made below.
         r_pop         <= '0;
         r_grant_valid <= 1'b0;
         case (r_state)
            tcl_pkg::ST_RESET: begin
               if (init) r_state <= tcl_pkg::ST_INIT;
            end
            tcl_pkg::ST_INIT: begin
               if (Umbral_bajo_in < Umbral_alto_in) begin
                  r_bajo    <= Umbral_bajo_in;
                  r_alto    <= Umbral_alto_in;
                  r_cfg_err <= 1'b0;
               end else begin
                  r_cfg_err <= 1'b1;
               end
               r_state <= tcl_pkg::ST_IDLE;
            end
            default: begin
               // IDLE and ACTIVE share the grant decision; a grant can be
               // issued on the same edge that leaves IDLE.
               if (init) begin
                  r_state <= tcl_pkg::ST_INIT;
               end else if (w_do_grant) begin
                  r_pop         <= NPORTS'(1) << w_sel_idx;
                  r_grant_valid <= 1'b1;
                  r_grant_idx   <= w_sel_idx;
                  r_last_grant  <= w_sel_idx;
                  r_state       <= tcl_pkg::ST_ACTIVE;
               end else begin
                  r_state <= tcl_pkg::ST_IDLE;
               end
            end
         endcase
      end
   end

   assign popOutP0    = r_pop[0];
   assign popOutP1    = r_pop[1];
   assign popOutP2    = r_pop[2];
   assign popOutP3    = r_pop[3];
   assign grantIdx    = r_grant_idx;
   assign grantValid  = r_grant_valid;
   assign Umbral_bajo = r_bajo;
   assign Umbral_alto = r_alto;
   assign cfgError    = r_cfg_err;
   assign state       = r_state;

endmodule

// File: tb/tb_tcl_pop_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcl_pop_arbiter
// Directed scenarios plus a randomized phase, all checked every cycle against
// a behavioural model of the arbiter's scheduling rules.
// -----------------------------------------------------------------------------
module tb_tcl_pop_arbiter;

   localparam int N = 4;

   // clock / reset
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   always #5 clk = ~clk;

   // DUT inputs
   logic       init       = 1'b0;
   logic [2:0] ub_in      = 3'd0;
   logic [2:0] ua_in      = 3'd0;
   logic [3:0] fifo_empty = 4'hF;
   logic [3:0] fifo_af    = 4'h0;
   logic       sink_ready = 1'b0;

   // DUT outputs
   logic       pop0, pop1, pop2, pop3;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic [2:0] ubajo, ualto;
   logic       cfg_error;
   logic [1:0] st;

   tcl_pop_arbiter #(.NPORTS(N), .IDX_W(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .Umbral_bajo_in (ub_in),
      .Umbral_alto_in (ua_in),
      .fifoEmpty      (fifo_empty),
      .fifoAlmostFull (fifo_af),
      .sinkReady      (sink_ready),
      .popOutP0       (pop0),
      .popOutP1       (pop1),
      .popOutP2       (pop2),
      .popOutP3       (pop3),
      .grantIdx       (grant_idx),
      .grantValid     (grant_valid),
      .Umbral_bajo    (ubajo),
      .Umbral_alto    (ualto),
      .cfgError       (cfg_error),
      .state          (st)
   );

   // scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // behavioural model: state 0=RESET 1=INIT 2=IDLE 3=ACTIVE
   int m_state, m_last, m_pop, m_gidx, m_bajo, m_alto, m_err;

   function automatic void m_reset();
      m_state = 0;
      m_last  = N - 1;
      m_pop   = -1;
      m_gidx  = 0;
      m_bajo  = 1;
      m_alto  = 6;
      m_err   = 0;
   endfunction

   // Urgent (almost-full) ports first by lowest index, else the next port
   // after the last grant going around the ring.
   function automatic int pick(input int prev);
      for (int i = 0; i < N; i++)
         if (!fifo_empty[i] && i != prev && fifo_af[i]) return i;
      for (int k = 1; k <= N; k++) begin
         int p;
         p = (m_last + k) % N;
         if (!fifo_empty[p] && p != prev) return p;
      end
      return -1;
   endfunction

   function automatic void model_edge();
      int prev;
      int g;
      prev  = m_pop;
      m_pop = -1;
      case (m_state)
         0: if (init) m_state = 1;
         1: begin
            if (ub_in < ua_in) begin
               m_bajo = ub_in;
               m_alto = ua_in;
               m_err  = 0;
            end else begin
               m_err = 1;
            end
            m_state = 2;
         end
         default: begin
            if (init) begin
               m_state = 1;
            end else begin
               g = pick(prev);
               if (sink_ready && g >= 0) begin
                  m_pop   = g;
                  m_gidx  = g;
                  m_last  = g;
                  m_state = 3;
               end else begin
                  m_state = 2;
               end
            end
         end
      endcase
   endfunction

   task automatic check_outputs(input string pfx);
      logic [3:0] exp_pops;
      exp_pops = (m_pop >= 0) ? (4'b0001 << m_pop) : 4'b0000;
      chk($sformatf("%s_state@%0d", pfx, cyc), 32'(st), 32'(m_state));
      chk($sformatf("%s_pops@%0d", pfx, cyc), 32'({pop3, pop2, pop1, pop0}), 32'(exp_pops));
      chk($sformatf("%s_gvalid@%0d", pfx, cyc), 32'(grant_valid), 32'(m_pop >= 0));
      chk($sformatf("%s_gidx@%0d", pfx, cyc), 32'(grant_idx), 32'(m_gidx));
      chk($sformatf("%s_ubajo@%0d", pfx, cyc), 32'(ubajo), 32'(m_bajo));
      chk($sformatf("%s_ualto@%0d", pfx, cyc), 32'(ualto), 32'(m_alto));
      chk($sformatf("%s_cfgerr@%0d", pfx, cyc), 32'(cfg_error), 32'(m_err));
   endtask

   // driver: inputs are set by the caller away from the edge; one clock,
   // model advance, then compare 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_outputs("cyc");
   endtask

   initial begin
      int found;
      m_reset();

      // reset values
      #2 reset = 1'b0;
      #1 check_outputs("rst");
      @(negedge clk) reset = 1'b1;

      // hold in RESET without init
      repeat (2) step();

      // rejected pair keeps reset thresholds and sets cfgError
      ub_in = 3'd5; ua_in = 3'd3; init = 1'b1;
      step();
      init = 1'b0;
      step();
      repeat (2) step();

      // valid pair clears cfgError
      ub_in = 3'd2; ua_in = 3'd5; init = 1'b1;
      step();
      init = 1'b0;
      step();

      // round-robin across all ports
      fifo_empty = 4'h0; sink_ready = 1'b1;
      repeat (5) step();

      // almost-full override on P2
      fifo_af = 4'b0100;
      repeat (2) step();
      fifo_af = 4'b0000;
      repeat (2) step();

      // only P1 has data: alternate-cycle pops, then sink stalls
      fifo_empty = 4'b1101;
      repeat (6) step();
      sink_ready = 1'b0;
      repeat (2) step();

      // randomized traffic with occasional re-init
      for (int i = 0; i < 400; i++) begin
         fifo_empty = 4'($urandom_range(0, 15));
         fifo_af    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         sink_ready = ($urandom_range(0, 4) != 0);
         init       = ($urandom_range(0, 24) == 0);
         ub_in      = 3'($urandom_range(0, 7));
         ua_in      = 3'($urandom_range(0, 7));
         step();
      end
      init = 1'b0;

      // drive until P3 is popping, then reset asynchronously mid-cycle
      fifo_empty = 4'h0; fifo_af = 4'h0; sink_ready = 1'b1;
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         step();
         if (pop3 === 1'b1) found = 1;
      end
      chk("p3_reached", 32'(found), 32'd1);
      #2 reset = 1'b0;
      #1;
      m_reset();
      chk("async_pop3_drop", 32'(pop3), 32'd0);
      check_outputs("arst");
      @(negedge clk) reset = 1'b1;

      // restart: first grant after reset is P0
      ub_in = 3'd2; ua_in = 3'd5; init = 1'b1;
      step();
      init = 1'b0;
      step();
      step();
      chk("first_grant_p0", 32'(pop0), 32'd1);
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
